// File: rtl/fifo_mem.sv
// fifo_mem: synchronous FIFO with internal DEPTH x DATA_BITS register memory.
// Owns its read/write pointers and occupancy count. Read data is registered:
// an accepted pop presents its word on data_out one cycle later, with valid_out.
//
// Ports:
//   clk          single clock, rising edge
//   reset_L      asynchronous active-low reset
//   data_in      write word
//   push / pop   write / read requests
//   umbral_alto  almost-full threshold  (almost_full  = count >= umbral_alto)
//   umbral_bajo  almost-empty threshold (almost_empty = count <= umbral_bajo)
//   data_out     registered read word, holds when no pop is accepted
//   valid_out    data_out carries a word popped at the previous edge
//   count        occupancy 0..DEPTH
//   full, empty  count==DEPTH / count==0
//   error        sticky: set by a rejected push or pop, cleared only by reset
module fifo_mem #(
   parameter int DATA_BITS = 10,
   parameter int ADDR_BITS = 3
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 push,
   input  logic                 pop,
   input  logic [ADDR_BITS:0]   umbral_alto,
   input  logic [ADDR_BITS:0]   umbral_bajo,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   output logic [ADDR_BITS:0]   count,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 error
);

   localparam int DEPTH = 2**ADDR_BITS;
   localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
   logic                 push_acc, pop_acc;

   // No bypass: a pop on an empty FIFO is rejected even with a same-cycle push.
   // A push on a full FIFO is accepted only when a pop frees a slot this edge.
   assign pop_acc  = pop && !empty;
   assign push_acc = push && (!full || pop_acc);

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= umbral_alto);
   assign almost_empty = (count <= umbral_bajo);

   // Storage has no reset; stale words are unreachable because pointers reset.
   always_ff @(posedge clk) begin
      if (push_acc) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         error     <= 1'b0;
      end else begin
         valid_out <= pop_acc;
         if (pop_acc) begin
            // Non-blocking read sees the old word when wr_ptr==rd_ptr (full push+pop).
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (push_acc && !pop_acc)      count <= count + 1'b1;
         else if (pop_acc && !push_acc) count <= count - 1'b1;
         if ((push && !push_acc) || (pop && !pop_acc)) error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_mem.sv
// Directed self-checking bench for fifo_mem (default DATA_BITS=10, ADDR_BITS=3).
module tb_fifo_mem;

   logic       clk = 1'b0;
   logic       reset_L;
   logic [9:0] data_in;
   logic       push, pop;
   logic [3:0] umbral_alto, umbral_bajo;
   logic [9:0] data_out;
   logic       valid_out;
   logic [3:0] count;
   logic       full, empty, almost_full, almost_empty, error;

   int checks = 0;
   int errors = 0;

   fifo_mem #(.DATA_BITS(10), .ADDR_BITS(3)) dut (
      .clk(clk), .reset_L(reset_L), .data_in(data_in), .push(push), .pop(pop),
      .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
      .data_out(data_out), .valid_out(valid_out), .count(count),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .error(error)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      push = 1'b0; pop = 1'b0;
      reset_L = 1'b0;
      #2;
      reset_L = 1'b1;
   endtask

   task automatic push_word(input logic [9:0] d);
      push = 1'b1; pop = 1'b0; data_in = d;
      cyc();
      push = 1'b0;
   endtask

   task automatic fill_1_to_8();
      for (int i = 1; i <= 8; i++) push_word(10'(i));
   endtask

   task automatic test_reset();
      umbral_alto = 4'd6; umbral_bajo = 4'd2;
      push = 1'b0; pop = 1'b0; data_in = '0;
      reset_L = 1'b0;
      #3;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", empty, full); end
      checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost got ae=%b af=%b exp 1 0", almost_empty, almost_full); end
      checks++; if (error !== 1'b0 || valid_out !== 1'b0 || data_out !== 10'h000) begin errors++; $display("FAIL reset_out got err=%b vld=%b dout=%h exp 0 0 000", error, valid_out, data_out); end
      umbral_alto = 4'd0;
      #1;
      checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL reset_af_alto0 got %b exp 1", almost_full); end
      umbral_alto = 4'd6;
      reset_L = 1'b1;
      cyc();
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         push_word(10'(i));
         checks++; if (count !== 4'(i)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, i); end
      end
      checks++; if (full !== 1'b1 || empty !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL fill_flags got full=%b empty=%b err=%b exp 1 0 0", full, empty, error); end
      pop = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         checks++; if (data_out !== 10'(i) || valid_out !== 1'b1) begin errors++; $display("FAIL drain_word got %h vld=%b exp %h vld=1", data_out, valid_out, 10'(i)); end
      end
      pop = 1'b0;
      checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL drain_empty got empty=%b count=%0d exp 1 0", empty, count); end
      cyc();
      checks++; if (valid_out !== 1'b0 || data_out !== 10'h008) begin errors++; $display("FAIL drain_hold got vld=%b dout=%h exp 0 008", valid_out, data_out); end
   endtask

   task automatic test_overflow();
      do_reset();
      fill_1_to_8();
      push_word(10'h3FF);
      checks++; if (count !== 4'd8 || error !== 1'b1 || full !== 1'b1) begin errors++; $display("FAIL ovf_state got count=%0d err=%b full=%b exp 8 1 1", count, error, full); end
      pop = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         checks++; if (data_out !== 10'(i)) begin errors++; $display("FAIL ovf_drain got %h exp %h", data_out, 10'(i)); end
      end
      pop = 1'b0;
      checks++; if (error !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL ovf_sticky got err=%b empty=%b exp 1 1", error, empty); end
   endtask

   task automatic test_full_pushpop();
      logic [9:0] exp_q [9];
      do_reset();
      fill_1_to_8();
      push = 1'b1; pop = 1'b1; data_in = 10'h2AA;
      cyc();
      push = 1'b0;
      checks++; if (data_out !== 10'h001 || valid_out !== 1'b1 || count !== 4'd8 || error !== 1'b0) begin errors++; $display("FAIL fullpp got dout=%h vld=%b count=%0d err=%b exp 001 1 8 0", data_out, valid_out, count, error); end
      exp_q = '{10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008, 10'h2AA, 10'h000};
      for (int i = 0; i < 8; i++) begin
         cyc();
         checks++; if (data_out !== exp_q[i] || valid_out !== 1'b1) begin errors++; $display("FAIL fullpp_drain got %h vld=%b exp %h", data_out, valid_out, exp_q[i]); end
      end
      pop = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullpp_empty got %b exp 1", empty); end
   endtask

   task automatic test_empty_pushpop();
      do_reset();
      push = 1'b1; pop = 1'b1; data_in = 10'h055;
      cyc();
      push = 1'b0; pop = 1'b0;
      checks++; if (valid_out !== 1'b0 || error !== 1'b1 || count !== 4'd1) begin errors++; $display("FAIL emptypp got vld=%b err=%b count=%0d exp 0 1 1", valid_out, error, count); end
      pop = 1'b1;
      cyc();
      pop = 1'b0;
      checks++; if (data_out !== 10'h055 || valid_out !== 1'b1) begin errors++; $display("FAIL emptypp_pop got %h vld=%b exp 055 1", data_out, valid_out); end
   endtask

   task automatic test_thresholds();
      do_reset();
      umbral_alto = 4'd6; umbral_bajo = 4'd2;
      #1;
      checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL thr_c0 got ae=%b af=%b exp 1 0", almost_empty, almost_full); end
      for (int i = 1; i <= 7; i++) begin
         push_word(10'(i + 16));
         checks++; if (almost_empty !== (i <= 2) || almost_full !== (i >= 6)) begin errors++; $display("FAIL thr_c%0d got ae=%b af=%b exp %b %b", i, almost_empty, almost_full, (i <= 2), (i >= 6)); end
      end
      umbral_alto = 4'd8;
      #1;
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL thr_alto8 got %b exp 0", almost_full); end
      umbral_bajo = 4'd8;
      #1;
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL thr_bajo8 got %b exp 1", almost_empty); end
      umbral_alto = 4'd6; umbral_bajo = 4'd2;
   endtask

   task automatic test_async_reset();
      do_reset();
      pop = 1'b1;
      cyc();
      pop = 1'b0;
      for (int i = 0; i < 6; i++) push_word(10'h0A1 + 10'(i));
      pop = 1'b1;
      cyc();
      pop = 1'b0;
      checks++; if (count !== 4'd5 || error !== 1'b1 || valid_out !== 1'b1 || data_out !== 10'h0A1) begin errors++; $display("FAIL arst_pre got count=%0d err=%b vld=%b dout=%h exp 5 1 1 0a1", count, error, valid_out, data_out); end
      #2;
      reset_L = 1'b0;
      #1;
      checks++; if (count !== 4'd0 || empty !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL arst_state got count=%0d empty=%b err=%b exp 0 1 0", count, empty, error); end
      checks++; if (valid_out !== 1'b0 || data_out !== 10'h000) begin errors++; $display("FAIL arst_out got vld=%b dout=%h exp 0 000", valid_out, data_out); end
      reset_L = 1'b1;
      push_word(10'h123);
      pop = 1'b1;
      cyc();
      pop = 1'b0;
      checks++; if (data_out !== 10'h123 || valid_out !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL arst_after got dout=%h vld=%b count=%0d exp 123 1 0", data_out, valid_out, count); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_pushpop();
      test_empty_pushpop();
      test_thresholds();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
